// File: rtl/ahb_spi_master_param.sv
// AHB-Lite slave SPI master with a parameterised word width, slave-select count and SCLK divider.
// Supports all four CPOL/CPHA modes, MSB- or LSB-first order, sticky DONE/OVR flags and a level interrupt.
module ahb_spi_master_param #(
  parameter int DATA_W = 8,
  parameter int NUM_SS = 4,
  parameter int DIV_W  = 8
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              HSEL,
  input  logic              HREADY,
  input  logic [31:0]       HADDR,
  input  logic [1:0]        HTRANS,
  input  logic              HWRITE,
  input  logic [31:0]       HWDATA,
  output logic [31:0]       HRDATA,
  output logic              HREADYOUT,
  output logic              SCLK,
  output logic              MOSI,
  input  logic              MISO,
  output logic [NUM_SS-1:0] SS_N,
  output logic              IRQ
);

  localparam int HC_W = $clog2(2 * DATA_W);
  localparam logic [HC_W-1:0] LAST_HALF = HC_W'(2 * DATA_W - 1);

  typedef enum logic [1:0] {S_IDLE, S_LEAD, S_XFER, S_TRAIL} state_t;

  typedef struct packed {
    logic [DIV_W-1:0] div;
    logic [7:0]       ss_sel;
    logic             auto_ss;
    logic             irq_en;
    logic             lsb_first;
    logic             cpha;
    logic             cpol;
  } ctrl_t;

  function automatic logic [DATA_W-1:0] bit_rev(input logic [DATA_W-1:0] d);
    logic [DATA_W-1:0] r;
    for (int i = 0; i < DATA_W; i++) r[i] = d[DATA_W-1-i];
    return r;
  endfunction

  state_t            state;
  ctrl_t             ctrl;
  logic              ap_sel;
  logic              ap_write;
  logic [1:0]        ap_addr;
  logic [DIV_W-1:0]  div_cnt;
  logic [HC_W-1:0]   half_cnt;
  logic [DATA_W-1:0] tx_sr;
  logic [DATA_W-1:0] rx_sr;
  logic [DATA_W-1:0] tx_data;
  logic [DATA_W-1:0] rx_data;
  logic [DATA_W-1:0] tx_init;
  logic              sclk_q;
  logic              mosi_q;
  logic              done;
  logic              ovr;
  logic              busy;
  logic              start;
  logic              half_end;
  logic              leading;
  logic              sample_now;
  logic              shift_now;
  logic              xfer_done;
  logic              wr_ctrl;
  logic              wr_tx;
  logic              wr_stat;
  logic              rd_rx;
  logic [31:0]       ctrl_rd;
  logic [NUM_SS-1:0] ss_mask;
  logic              unused_bits;

  assign unused_bits = ^{HADDR[31:4], HADDR[1:0], HTRANS[0], HWDATA};

  // Address phase is captured here; the access itself completes in the following data-phase cycle.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      ap_sel   <= 1'b0;
      ap_write <= 1'b0;
      ap_addr  <= 2'd0;
    end else if (HREADY) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      ap_sel   <= HSEL & HTRANS[1];
      ap_write <= HWRITE;
      ap_addr  <= HADDR[3:2];
    end
  end

  assign wr_ctrl  = ap_sel &  ap_write & (ap_addr == 2'd0);
  assign wr_tx    = ap_sel &  ap_write & (ap_addr == 2'd1);
  assign wr_stat  = ap_sel &  ap_write & (ap_addr == 2'd3);
  assign rd_rx    = ap_sel & ~ap_write & (ap_addr == 2'd2);

  assign busy       = (state != S_IDLE);
  assign start      = wr_tx & ~busy;
  assign half_end   = (div_cnt == '0);
  assign leading    = ~half_cnt[0];
  assign sample_now = leading ^ ctrl.cpha;
  assign shift_now  = ctrl.cpha ? (leading & (half_cnt != '0)) : (~leading & (half_cnt != LAST_HALF));
  assign xfer_done  = (state == S_TRAIL) & half_end;
  assign tx_init    = ctrl.lsb_first ? bit_rev(HWDATA[DATA_W-1:0]) : HWDATA[DATA_W-1:0];

  // The shifters always move MSB-ward; LSB-first order is handled by reversing on load and on unload.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state    <= S_IDLE;
      div_cnt  <= '0;
      half_cnt <= '0;
      tx_sr    <= '0;
      rx_sr    <= '0;
      rx_data  <= '0;
      sclk_q   <= 1'b0;
      mosi_q   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          sclk_q <= ctrl.cpol;
          if (start) begin
            state    <= S_LEAD;
            div_cnt  <= ctrl.div;
            half_cnt <= '0;
            tx_sr    <= tx_init;
            rx_sr    <= '0;
            mosi_q   <= tx_init[DATA_W-1];
          end else begin
            mosi_q <= 1'b0;
          end
        end
        S_LEAD: begin
          if (half_end) begin
            state   <= S_XFER;
            div_cnt <= ctrl.div;
          end else begin
            div_cnt <= div_cnt - DIV_W'(1);
          end
        end
        S_XFER: begin
          if (half_end) begin
            div_cnt  <= ctrl.div;
            sclk_q   <= ~sclk_q;
            half_cnt <= half_cnt + HC_W'(1);
            if (sample_now) rx_sr <= {rx_sr[DATA_W-2:0], MISO};
            if (shift_now) begin
              tx_sr  <= tx_sr << 1;
              mosi_q <= tx_sr[DATA_W-2];
            end
            if (half_cnt == LAST_HALF) state <= S_TRAIL;
          end else begin
            div_cnt <= div_cnt - DIV_W'(1);
          end
        end
        S_TRAIL: begin
          if (half_end) begin
            state   <= S_IDLE;
            rx_data <= ctrl.lsb_first ? bit_rev(rx_sr) : rx_sr;
          end else begin
            div_cnt <= div_cnt - DIV_W'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Flag updates list the set condition first so a coincident clear loses.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      ctrl    <= '0;
      tx_data <= '0;
      done    <= 1'b0;
      ovr     <= 1'b0;
    end else begin
      if (wr_ctrl && !busy) begin
        ctrl <= '{div: HWDATA[16 +: DIV_W], ss_sel: HWDATA[15:8], auto_ss: HWDATA[4],
                  irq_en: HWDATA[3], lsb_first: HWDATA[2], cpha: HWDATA[1], cpol: HWDATA[0]};
      end
      if (start) tx_data <= HWDATA[DATA_W-1:0];
      if (xfer_done) done <= 1'b1;
      else if ((wr_stat && HWDATA[1]) || rd_rx) done <= 1'b0;
      if (wr_tx && busy) ovr <= 1'b1;
      else if (wr_stat && HWDATA[2]) ovr <= 1'b0;
    end
  end

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    ctrl_rd              = '0;
    ctrl_rd[16 +: DIV_W] = ctrl.div;
    ctrl_rd[15:8]        = ctrl.ss_sel;
    ctrl_rd[4:0]         = {ctrl.auto_ss, ctrl.irq_en, ctrl.lsb_first, ctrl.cpha, ctrl.cpol};
  end

  always_comb begin
    HRDATA = '0;
    if (ap_sel && !ap_write) begin
      case (ap_addr)
        2'd0:    HRDATA = ctrl_rd;
        2'd1:    HRDATA = 32'(tx_data);
        2'd2:    HRDATA = 32'(rx_data);
        default: HRDATA = {29'd0, ovr, done, busy};
      endcase
    end
  end

  assign ss_mask   = ctrl.ss_sel[NUM_SS-1:0];
  assign SS_N      = ctrl.auto_ss ? ~(ss_mask & {NUM_SS{busy}}) : ~ss_mask;
  assign SCLK      = sclk_q;
  assign MOSI      = mosi_q;
  assign IRQ       = ctrl.irq_en & done;
  assign HREADYOUT = 1'b1;

endmodule

// File: tb/tb_ahb_spi_master_param.sv
// Bench for ahb_spi_master_param: bus reads are scored against a queue of expected words,
// and a behavioural SPI slave captures MOSI and can return a fixed word on MISO.
module tb_ahb_spi_master_param;

  localparam logic [1:0] A_CTRL = 2'd0;
  localparam logic [1:0] A_TX   = 2'd1;
  localparam logic [1:0] A_RX   = 2'd2;
  localparam logic [1:0] A_STAT = 2'd3;

  typedef struct {
    string       name;
    logic [31:0] exp;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        hsel = 1'b0;
  logic        hready = 1'b1;
  logic [31:0] haddr = '0;
  logic [1:0]  htrans = 2'b00;
  logic        hwrite = 1'b0;
  logic [31:0] hwdata = '0;
  logic [31:0] hrdata;
  logic        hreadyout;
  logic        sclk;
  logic        mosi;
  logic        miso;
  logic [3:0]  ss_n;
  logic        irq;

  logic        loopback = 1'b1;
  logic        slv_cpol = 1'b0;
  logic        slv_cpha = 1'b0;
  logic        slv_lsb  = 1'b0;
  logic [7:0]  slv_tx   = '0;
  logic [7:0]  slv_rx   = '0;
  logic        slv_miso = 1'b0;
  int          slv_idx  = 0;

  exp_t        exp_q[$];
  logic        mon_rd = 1'b0;
  int          n_checks = 0;
  int          n_fail = 0;

  ahb_spi_master_param #(.DATA_W(8), .NUM_SS(4), .DIV_W(8)) dut (
    .HCLK(clk), .HRESETn(rst_n), .HSEL(hsel), .HREADY(hready), .HADDR(haddr),
    .HTRANS(htrans), .HWRITE(hwrite), .HWDATA(hwdata), .HRDATA(hrdata),
    .HREADYOUT(hreadyout), .SCLK(sclk), .MOSI(mosi), .MISO(miso), .SS_N(ss_n), .IRQ(irq)
  );

  always #5 clk = ~clk;

  assign miso = loopback ? mosi : slv_miso;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Read monitor: a read address phase seen at a rising edge is scored at the next falling edge.
  always @(posedge clk) mon_rd <= rst_n & hsel & htrans[1] & ~hwrite & hready;

  always @(negedge clk) begin
    if (mon_rd) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_read: got 0x%08h expected no read", hrdata);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check(e.name, hrdata, e.exp);
      end
    end
  end

  // Behavioural slave on SS_N[0]; its bit order and mode are set by the stimulus.
  function automatic logic slv_bit(input int i);
    if (i > 7) return 1'b0;
    return slv_lsb ? slv_tx[i] : slv_tx[7-i];
  endfunction

  always @(negedge ss_n[0]) begin
    slv_idx = 0;
    slv_rx  = '0;
    if (!slv_cpha) slv_miso = slv_bit(0);
  end

  always @(sclk) begin
    if (rst_n && ss_n[0] == 1'b0) begin
      if (sclk != slv_cpol) begin
        if (slv_cpha) slv_miso = slv_bit(slv_idx);
        else slv_rx = slv_lsb ? {mosi, slv_rx[7:1]} : {slv_rx[6:0], mosi};
      end else begin
        if (slv_cpha) begin
          slv_rx = slv_lsb ? {mosi, slv_rx[7:1]} : {slv_rx[6:0], mosi};
          slv_idx++;
        end else begin
          slv_idx++;
          slv_miso = slv_bit(slv_idx);
        end
      end
    end
  end

  task automatic bus_write(input logic [1:0] ra, input logic [31:0] d);
    @(negedge clk);
    hsel = 1'b1; htrans = 2'b10; hwrite = 1'b1; haddr = {28'h0, ra, 2'b00};
    @(negedge clk);
    hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0; hwdata = d;
  endtask

  task automatic bus_read(input string name, input logic [1:0] ra, input logic [31:0] exp);
    exp_q.push_back('{name, exp});
    @(negedge clk);
    hsel = 1'b1; htrans = 2'b10; hwrite = 1'b0; haddr = {28'h0, ra, 2'b00};
    @(negedge clk);
    hsel = 1'b0; htrans = 2'b00;
  endtask

  task automatic set_slave(input logic cpol, input logic cpha, input logic lsb, input logic [7:0] tx,
                           input logic lb);
    slv_cpol = cpol; slv_cpha = cpha; slv_lsb = lsb; slv_tx = tx; loopback = lb;
  endtask

  // Starts a transfer and observes it until SS_N[0] deasserts, bounded by a cycle budget.
  task automatic run_xfer(input string name, input logic [7:0] tx, output int busy, output int rises,
                          output int half, output logic [3:0] ss_seen);
    int   first;
    int   second;
    logic prev;
    bit   seen;
    bit   timed_out;
    first = -1; second = -1; seen = 0; timed_out = 1;
    busy = 0; rises = 0; ss_seen = '1;
    bus_write(A_TX, {24'h0, tx});
    prev = sclk;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (sclk != prev) begin
        if (sclk) rises++;
        if (first < 0) first = i;
        else if (second < 0) second = i;
        prev = sclk;
      end
      if (ss_n[0] == 1'b0) begin
        if (!seen) ss_seen = ss_n;
        seen = 1;
        busy++;
      end else if (seen) begin
        timed_out = 0;
        break;
      end
    end
    half = second - first;
    check({name, "_timeout"}, 32'(timed_out), 32'd0);
  endtask

  task automatic wait_idle(input string name);
    bit timed_out;
    timed_out = 1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (ss_n[0] == 1'b1) begin
        timed_out = 0;
        break;
      end
    end
    check({name, "_timeout"}, 32'(timed_out), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int         busy;
    int         rises;
    int         half;
    logic [3:0] ss_seen;

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_ss_n", 32'(ss_n), 32'hF);
    check("rst_sclk", 32'(sclk), 32'd0);
    check("rst_mosi", 32'(mosi), 32'd0);
    check("rst_irq",  32'(irq),  32'd0);
    check("rst_hrdata", hrdata, 32'd0);
    check("hreadyout", 32'(hreadyout), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    bus_read("rst_status", A_STAT, 32'h0);
    bus_read("rst_ctrl",   A_CTRL, 32'h0);
    bus_read("rst_rxdata", A_RX,   32'h0);
    bus_read("rst_txdata", A_TX,   32'h0);

    // Manual slave select; SS_SEL bits above NUM_SS have no pin.
    bus_write(A_CTRL, 32'h0000_F500);
    @(negedge clk);
    check("manual_ss_n", 32'(ss_n), 32'hA);
    bus_read("manual_ctrl", A_CTRL, 32'h0000_F500);

    // Mode 0, DIV=0, loopback, 0xA5.
    set_slave(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    bus_write(A_CTRL, 32'h0000_0110);
    run_xfer("m0", 8'hA5, busy, rises, half, ss_seen);
    check("m0_busy",   32'(busy),    32'd18);
    check("m0_rises",  32'(rises),   32'd8);
    check("m0_ss_n",   32'(ss_seen), 32'hE);
    check("m0_mosi",   32'(slv_rx),  32'hA5);
    bus_read("m0_status", A_STAT, 32'h2);
    bus_read("m0_rxdata", A_RX,   32'hA5);
    bus_read("m0_status_clr", A_STAT, 32'h0);

    // Mode 3, LSB first, DIV=3, slave returns 0xC3.
    set_slave(1'b1, 1'b1, 1'b1, 8'hC3, 1'b0);
    bus_write(A_CTRL, 32'h0003_0117);
    repeat (2) @(negedge clk);
    check("m3_sclk_idle", 32'(sclk), 32'd1);
    run_xfer("m3", 8'h3C, busy, rises, half, ss_seen);
    check("m3_busy",  32'(busy),   32'd72);
    check("m3_rises", 32'(rises),  32'd8);
    check("m3_half",  32'(half),   32'd4);
    check("m3_mosi",  32'(slv_rx), 32'h3C);
    check("m3_sclk_end", 32'(sclk), 32'd1);
    bus_read("m3_rxdata", A_RX, 32'hC3);

    // Overrun and CTRL lock while busy.
    set_slave(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    bus_write(A_CTRL, 32'h0003_0110);
    bus_write(A_TX, 32'h0000_005A);
    bus_write(A_TX, 32'h0000_00FF);
    bus_write(A_CTRL, 32'h0000_0111);
    bus_read("ovr_status_busy", A_STAT, 32'h5);
    bus_read("ovr_txdata", A_TX, 32'h5A);
    bus_read("ovr_ctrl", A_CTRL, 32'h0003_0110);
    wait_idle("ovr");
    check("ovr_mosi", 32'(slv_rx), 32'h5A);
    bus_read("ovr_status_done", A_STAT, 32'h6);
    bus_write(A_STAT, 32'h4);
    bus_read("ovr_status_clr", A_STAT, 32'h2);
    bus_read("ovr_rxdata", A_RX, 32'h5A);
    bus_read("ovr_status_final", A_STAT, 32'h0);

    // Interrupt, and a STATUS clear landing on the same edge that sets DONE.
    bus_write(A_CTRL, 32'h0000_0118);
    bus_write(A_TX, 32'h0000_0081);
    repeat (16) @(negedge clk);
    bus_write(A_STAT, 32'h2);
    @(negedge clk);
    check("irq_set", 32'(irq), 32'd1);
    bus_read("irq_status", A_STAT, 32'h2);
    bus_read("irq_rxdata", A_RX, 32'h81);
    check("irq_in_read", 32'(irq), 32'd1);
    @(negedge clk);
    check("irq_cleared", 32'(irq), 32'd0);

    // Reset asserted mid-transfer.
    bus_write(A_CTRL, 32'h0003_0110);
    bus_write(A_TX, 32'h0000_00F0);
    repeat (20) @(negedge clk);
    check("midrst_active", 32'(ss_n), 32'hE);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_ss_n", 32'(ss_n), 32'hF);
    check("midrst_sclk", 32'(sclk), 32'd0);
    check("midrst_mosi", 32'(mosi), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bus_read("midrst_status", A_STAT, 32'h0);
    bus_read("midrst_ctrl",   A_CTRL, 32'h0);
    bus_read("midrst_rxdata", A_RX,   32'h0);
    bus_write(A_CTRL, 32'h0000_0110);
    run_xfer("post", 8'h3C, busy, rises, half, ss_seen);
    check("post_busy", 32'(busy), 32'd18);
    check("post_mosi", 32'(slv_rx), 32'h3C);
    bus_read("post_rxdata", A_RX, 32'h3C);

    repeat (2) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
